// File: rtl/sa_autosa_sdp_core_pack_var_if.sv
// Handshake bundle for the word-to-segment packer: a wide word stream in, a narrow segment stream out.
// The slave modport is the packer's view; the master modport is the view of whatever drives it.
interface sa_autosa_sdp_core_pack_var_if #(
   parameter int IW = 512,
   parameter int OW = 128
);
   logic          inp_pvld;
   logic          inp_prdy;
   logic [IW-1:0] inp_data;
   logic [4:0]    inp_nseg;
   logic          out_pvld;
   logic          out_prdy;
   logic [OW-1:0] out_data;
   logic          out_last;

   modport master (
      output inp_pvld, inp_data, inp_nseg, out_prdy,
      input  inp_prdy, out_pvld, out_data, out_last
   );

   modport slave (
      input  inp_pvld, inp_data, inp_nseg, out_prdy,
      output inp_prdy, out_pvld, out_data, out_last
   );
endinterface

// File: rtl/sa_autosa_sdp_core_pack_var.sv
// Serialises IW-bit words into nseg OW-bit segments, with a CUR/NXT skid pair so inp_prdy is purely registered.
// Define SA_AUTOSA_SDP_PACK_OUT_REG_EN to add a flopped output stage (2-cycle latency, same throughput).
module sa_autosa_sdp_core_pack_var #(
   parameter int IW    = 512,
   parameter int OW    = 128,
   parameter int RATIO = IW / OW
) (
   input logic                         autosa_core_clk,
   input logic                         autosa_core_rstn,
   sa_autosa_sdp_core_pack_var_if.slave bus
);
   localparam logic [4:0] RATIO_N = 5'(RATIO);

   logic          cur_valid;
   logic          nxt_valid;
   logic [IW-1:0] cur_data;
   logic [IW-1:0] nxt_data;
   logic [4:0]    cur_nseg;
   logic [4:0]    nxt_nseg;
   logic [3:0]    seg_cnt;

   logic [4:0]    in_nseg;
   logic [OW-1:0] core_data;
   logic [OW-1:0] segs [RATIO];
   logic          accept;
   logic          core_rdy;
   logic          core_last;
   logic          xfer;
   logic          last_xfer;
   logic          load_cur_in;
   logic          load_cur_nxt;
   logic          load_nxt;

   // Out-of-range segment counts fall back to a full word.
   always_comb begin
      in_nseg = bus.inp_nseg;
      if (bus.inp_nseg == 5'd0 || bus.inp_nseg > RATIO_N)
         in_nseg = RATIO_N;
   end

   assign bus.inp_prdy = !nxt_valid;
   assign accept       = bus.inp_pvld && !nxt_valid;
   assign core_last    = ({1'b0, seg_cnt} == (cur_nseg - 5'd1));
   assign xfer         = cur_valid && core_rdy;
   assign last_xfer    = xfer && core_last;

   // accept already implies NXT is empty, so a fresh word only lands in CUR when CUR frees up.
   assign load_cur_nxt = last_xfer && nxt_valid;
   assign load_cur_in  = accept && (!cur_valid || last_xfer);
   assign load_nxt     = accept && cur_valid && !last_xfer;

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         cur_valid <= 1'b0;
         nxt_valid <= 1'b0;
         seg_cnt   <= 4'd0;
      end else begin
         if (load_cur_nxt || load_cur_in)
            cur_valid <= 1'b1;
         else if (last_xfer)
            cur_valid <= 1'b0;

         if (load_nxt)
            nxt_valid <= 1'b1;
         else if (load_cur_nxt)
            nxt_valid <= 1'b0;

         if (last_xfer)
            seg_cnt <= 4'd0;
         else if (xfer)
            seg_cnt <= seg_cnt + 4'd1;
      end
   end

   always_ff @(posedge autosa_core_clk) begin
      if (load_cur_nxt) begin
         cur_data <= nxt_data;
         cur_nseg <= nxt_nseg;
      end else if (load_cur_in) begin
         cur_data <= bus.inp_data;
         cur_nseg <= in_nseg;
      end
      if (load_nxt) begin
         nxt_data <= bus.inp_data;
         nxt_nseg <= in_nseg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RATIO; gi++) begin : g_seg
         assign segs[gi] = cur_data[gi*OW +: OW];
      end
   endgenerate

   always_comb begin
      core_data = '0;
      for (int i = 0; i < RATIO; i++)
         if (seg_cnt == 4'(i))
            core_data = segs[i];
   end

`ifdef SA_AUTOSA_SDP_PACK_OUT_REG_EN
   logic          oreg_vld;
   logic          oreg_last;
   logic [OW-1:0] oreg_data;

   assign core_rdy = !oreg_vld || bus.out_prdy;

   // Data is cleared alongside valid so an idle output reads as zero straight from the flops.
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         oreg_vld  <= 1'b0;
         oreg_last <= 1'b0;
         oreg_data <= '0;
      end else if (core_rdy) begin
         oreg_vld  <= cur_valid;
         oreg_last <= cur_valid && core_last;
         oreg_data <= cur_valid ? core_data : '0;
      end
   end

   assign bus.out_pvld = oreg_vld;
   assign bus.out_last = oreg_last;
   assign bus.out_data = oreg_data;
`else
   assign core_rdy     = bus.out_prdy;
   assign bus.out_pvld = cur_valid;
   assign bus.out_last = cur_valid && core_last;
   assign bus.out_data = cur_valid ? core_data : '0;
`endif
endmodule

// File: doc/sa_autosa_sdp_core_pack_var.md
SA_AUTOSA_SDP_CORE_PACK_VAR -- requirements
Module: SA_AUTOSA_SDP_CORE_pack_var

Interface
REQ-001 SHALL have parameter IW, default 512, input word width in bits.
REQ-002 SHALL have parameter OW, default 128, output segment width in bits.
REQ-003 SHALL have parameter RATIO, default IW/OW, segments per word; legal 1..16; IW SHALL equal OW*RATIO.
REQ-004 SHALL have port autosa_core_clk, input, 1, single clock; all state on its rising edge.
REQ-005 SHALL have port autosa_core_rstn, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port inp_pvld, input, 1, input word valid.
REQ-007 SHALL have port inp_prdy, output, 1, input word ready.
REQ-008 SHALL have port inp_data, input, IW, input word; segment k = bits [OW*k+OW-1:OW*k].
REQ-009 SHALL have port inp_nseg, input, 5, count of valid segments in the word, 1..RATIO.
REQ-010 SHALL have port out_pvld, output, 1, segment valid.
REQ-011 SHALL have port out_prdy, input, 1, segment ready.
REQ-012 SHALL have port out_data, output, OW, current segment.
REQ-013 SHALL have port out_last, output, 1, high on the final valid segment of a word.

Function
REQ-014 SHALL accept a word when inp_pvld & inp_prdy; transfer a segment when out_pvld & out_prdy.
REQ-015 SHALL hold two word entries, CUR (serialising) and NXT (skid), each storing data plus nseg.
REQ-016 SHALL drive inp_prdy = !NXT_valid, from registered state only, with no combinational path from out_prdy.
REQ-017 SHALL load an accepted word into CUR when CUR is empty or its last segment transfers this cycle and NXT is empty; otherwise into NXT.
REQ-018 SHALL move NXT to CUR in the cycle CUR's last segment transfers; an input accepted the same cycle SHALL go to NXT.
REQ-019 SHALL emit segments in order 0,1,...,nseg-1, selected by a 4-bit counter seg_cnt; segments >= nseg are never emitted.
REQ-020 SHALL treat inp_nseg of 0 or greater than RATIO as RATIO.
REQ-021 SHALL assert out_last when seg_cnt == nseg-1; seg_cnt clears to 0 on that transfer, otherwise increments on each transfer.
REQ-022 SHALL have latency of 1 cycle from input acceptance into an empty block to out_pvld high.
REQ-023 SHALL sustain one segment per cycle across word boundaries with no bubble while NXT is valid or input arrives in time.
REQ-024 SHALL hold out_data, out_last and out_pvld stable while out_pvld & !out_prdy.
REQ-025 SHALL drive out_data = 0 and out_last = 0 whenever out_pvld is low.

Reset
REQ-026 SHALL, while autosa_core_rstn is low, force CUR_valid=0, NXT_valid=0, seg_cnt=0, out_pvld=0, out_last=0, inp_prdy=1; data registers are not reset.
REQ-027 SHALL discard any partially serialised word on reset assertion mid-operation; after release, the first output is segment 0 of the next accepted word.

Configuration
REQ-028 SHALL, with macro SA_AUTOSA_SDP_PACK_OUT_REG_EN defined, add a registered output stage that is reloaded when empty or out_prdy is high: out_pvld/out_data/out_last come directly from flops, latency is 2 cycles, and throughput stays one segment per cycle.
REQ-029 SHALL, without SA_AUTOSA_SDP_PACK_OUT_REG_EN, drive the outputs combinationally from CUR and seg_cnt with latency 1.

Verification
REQ-030 SHALL cover: RATIO=4, word 0x..DDDD_CCCC_BBBB_AAAA, nseg=4, out_prdy=1 -> 4 beats A,B,C,D, out_last only on D, first beat 1 cycle after acceptance.
REQ-031 SHALL cover: nseg=2, then nseg=0 -> 2 beats (last on beat 2), then 4 beats (0 treated as RATIO).
REQ-032 SHALL cover: back-to-back words with out_prdy=1 -> continuous out_pvld, no gap; inp_prdy drops only while NXT is full.
REQ-033 SHALL cover: out_prdy low 5 cycles mid-word -> out_data/out_last held; with CUR+NXT full, inp_prdy=0 and no word lost.
REQ-034 SHALL cover: reset asserted after segment 1 of 4 -> out_pvld=0, inp_prdy=1 immediately; the next word starts at segment 0.
REQ-035 SHALL cover: REQ-030 repeated with SA_AUTOSA_SDP_PACK_OUT_REG_EN defined -> identical beat sequence, first beat 2 cycles after acceptance.
